// File: rtl/cla_io_stage.sv
// Registered valid/ready wrapper around an external combinational adder; derives carry-out and signed overflow.
// Latency: 2 cycles from operand acceptance to out_valid; one add per cycle with out_ready high.
// Backpressure: holds up to two pairs (operand + result register), in_ready recovers in the same cycle as out_ready.
module cla_io_stage #(
    parameter int NBIT = 16,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NBIT-1:0] in_a,
    input  logic [NBIT-1:0] in_b,
    output logic [NBIT-1:0] add_a,
    output logic [NBIT-1:0] add_b,
    input  logic [NBIT-1:0] add_s,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NBIT-1:0] out_s,
    output logic            out_cout,
    output logic            out_ovf,
    output logic            ovf_sticky,
    input  logic            ovf_clr,
    output logic [CNTW-1:0] txn_count
);

    typedef struct packed {
        logic [NBIT-1:0] s;
        logic            cout;
        logic            ovf;
    } res_t;

    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    logic v1;
    logic v2;
    logic adv2;
    logic accept;
    logic deliver;
    logic msb_a;
    logic msb_b;
    logic msb_s;
    res_t res_d;
    res_t res_q;

    // Stage 1 may move forward whenever stage 2 is empty or draining this cycle.
    assign adv2     = v1 & (~v2 | out_ready);
    assign in_ready = ~v1 | adv2;
    assign accept   = in_valid & in_ready;
    assign deliver  = v2 & out_ready;

    always_comb begin
        msb_a      = add_a[NBIT-1];
        msb_b      = add_b[NBIT-1];
        msb_s      = add_s[NBIT-1];
        res_d      = '0;
        res_d.s    = add_s;
        res_d.cout = (msb_a & msb_b) | ((msb_a ^ msb_b) & ~msb_s);
        res_d.ovf  = (msb_a ~^ msb_b) & (msb_s ^ msb_a);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            add_a <= '0;
            add_b <= '0;
        end else if (accept) begin
            v1    <= 1'b1;
            add_a <= in_a;
            add_b <= in_b;
        end else if (adv2) begin
            v1    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            res_q <= '0;
        end else if (adv2) begin
            v2    <= 1'b1;
            res_q <= res_d;
        end else if (out_ready) begin
            v2    <= 1'b0;
        end
    end

    // A coinciding overflow delivery takes priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            txn_count  <= '0;
        end else begin
            if (deliver && res_q.ovf) begin
                ovf_sticky <= 1'b1;
            end else if (ovf_clr) begin
                ovf_sticky <= 1'b0;
            end
            if (deliver) begin
                txn_count <= txn_count + CNT_ONE;
            end
        end
    end

    assign out_valid = v2;
    assign out_s     = res_q.s;
    assign out_cout  = res_q.cout;
    assign out_ovf   = res_q.ovf;

endmodule

// File: tb/tb_cla_io_stage.sv
// Randomised and directed bench for cla_io_stage with a queue-based reference model.
module tb_cla_io_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_ready = 1'b0;
    logic        ovf_clr = 1'b0;

    logic        in_ready, out_valid, out_cout, out_ovf, ovf_sticky;
    logic [15:0] add_a, add_b, add_s, out_s, txn_count;

    logic        in_ready2, out_valid2, out_cout2, out_ovf2, ovf_sticky2;
    logic [15:0] add_a2, add_b2, add_s2, out_s2;
    logic [1:0]  txn_count2;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign add_s  = add_a + add_b;
    assign add_s2 = add_a2 + add_b2;

    cla_io_stage #(.NBIT(16), .CNTW(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b), .add_s(add_s),
        .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
        .out_cout(out_cout), .out_ovf(out_ovf), .ovf_sticky(ovf_sticky),
        .ovf_clr(ovf_clr), .txn_count(txn_count)
    );

    cla_io_stage #(.NBIT(16), .CNTW(2)) u_dut_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .add_a(add_a2), .add_b(add_b2), .add_s(add_s2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_s(out_s2),
        .out_cout(out_cout2), .out_ovf(out_ovf2), .ovf_sticky(ovf_sticky2),
        .ovf_clr(ovf_clr), .txn_count(txn_count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          due;
    } exp_t;

    exp_t q[$];
    int   nneg = 0;
    int   mcnt = 0;
    logic msticky = 1'b0;

    function automatic exp_t model_add(input logic [15:0] a, input logic [15:0] b, input int due);
        exp_t e;
        int   usum;
        int   ssum;
        usum  = int'(a) + int'(b);
        ssum  = int'($signed(a)) + int'($signed(b));
        e.s   = usum[15:0];
        e.c   = (usum > 65535);
        e.o   = (ssum > 32767) || (ssum < -32768);
        e.due = due;
        return e;
    endfunction

    always @(negedge clk) begin
        logic exp_ov;
        logic exp_ir;
        if (!rst_n) begin
            q.delete();
            mcnt    = 0;
            msticky = 1'b0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_s", out_s, 0);
            chk("rst_txn", txn_count, 0);
            chk("rst_sticky", ovf_sticky, 0);
        end else begin
            exp_ov = (q.size() > 0) && (nneg >= q[0].due);
            exp_ir = (q.size() < 2) || out_ready;
            chk("m_in_ready", in_ready, exp_ir);
            chk("m_out_valid", out_valid, exp_ov);
            chk("m_txn", txn_count, mcnt % 65536);
            chk("m_txn_c2", txn_count2, mcnt % 4);
            chk("m_sticky", ovf_sticky, msticky);
            if (exp_ov && out_valid) begin
                chk("m_out_s", out_s, q[0].s);
                chk("m_cout", out_cout, q[0].c);
                chk("m_ovf", out_ovf, q[0].o);
            end
            if (exp_ov && out_ready) begin
                if (q[0].o) msticky = 1'b1;
                else if (ovf_clr) msticky = 1'b0;
                void'(q.pop_front());
                mcnt++;
            end else if (ovf_clr) begin
                msticky = 1'b0;
            end
            if (in_valid && exp_ir) q.push_back(model_add(in_a, in_b, nneg + 2));
        end
        nneg++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int i = 0; i < 100 && !done; i++) begin
            if (in_ready) done = 1;
            tick();
        end
        in_valid = 1'b0;
        if (!done) chk("push_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [15:0] pa [4] = '{16'd0, 16'd2, 16'd124, 16'd54};
    logic [15:0] pb [4] = '{16'd0, 16'd3, 16'd3, 16'd43};
    logic [15:0] ps [4] = '{16'd0, 16'd5, 16'd127, 16'd97};
    logic [15:0] corner [6] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001, 16'h8001};

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("init_in_ready", in_ready, 1);
        chk("init_out_valid", out_valid, 0);
        chk("init_txn", txn_count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;

        // single adds and latency
        push(16'd2, 16'd3);
        chk("lat_not_yet", out_valid, 0);
        tick();
        chk("lat_valid", out_valid, 1);
        chk("add5_s", out_s, 16'd5);
        chk("add5_cout", out_cout, 0);
        chk("add5_ovf", out_ovf, 0);
        push(16'd124, 16'd15);
        tick();
        chk("add139_s", out_s, 16'd139);

        // back-to-back stream
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a = pa[i];
            in_b = pb[i];
            tick();
            if (i >= 1) chk("stream_s", out_s, ps[i-1]);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_s_last", out_s, ps[3]);
        tick();
        chk("stream_txn", txn_count, 4);

        // boundaries
        push(16'hFFFF, 16'h0001);
        tick();
        chk("ffff_s", out_s, 16'h0000);
        chk("ffff_cout", out_cout, 1);
        chk("ffff_ovf", out_ovf, 0);
        push(16'h7FFF, 16'h0001);
        tick();
        chk("7fff_s", out_s, 16'h8000);
        chk("7fff_cout", out_cout, 0);
        chk("7fff_ovf", out_ovf, 1);
        tick();
        chk("7fff_sticky", ovf_sticky, 1);
        push(16'h8000, 16'h8000);
        tick();
        chk("8000_s", out_s, 16'h0000);
        chk("8000_cout", out_cout, 1);
        chk("8000_ovf", out_ovf, 1);
        tick();

        // backpressure
        out_ready = 1'b0;
        push(16'd10, 16'd1);
        push(16'd20, 16'd2);
        in_valid = 1'b1;
        in_a = 16'd30;
        in_b = 16'd3;
        #1;
        chk("bp_full", in_ready, 0);
        chk("bp_hold0", out_s, 16'd11);
        tick();
        tick();
        chk("bp_still_full", in_ready, 0);
        chk("bp_hold1", out_s, 16'd11);
        out_ready = 1'b1;
        #1;
        chk("bp_release", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_second", out_s, 16'd22);
        tick();
        chk("bp_third", out_s, 16'd33);
        tick();
        tick();

        // reset with both stages full
        out_ready = 1'b0;
        push(16'd1, 16'd2);
        push(16'd3, 16'd4);
        rst_n = 1'b0;
        #1;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_out_s", out_s, 0);
        chk("mid_add_a", add_a, 0);
        chk("mid_txn", txn_count, 0);
        chk("mid_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_stale", out_valid, 0);
        end
        chk("mid_txn_after", txn_count, 0);

        // sticky priority and clear
        ovf_clr = 1'b1;
        push(16'h7FFF, 16'h0001);
        chk("clr_sticky0", ovf_sticky, 0);
        tick();
        tick();
        chk("clr_set_wins", ovf_sticky, 1);
        tick();
        chk("clr_alone", ovf_sticky, 0);
        ovf_clr = 1'b0;

        // narrow counter wrap
        do_reset();
        for (int i = 0; i < 5; i++) push(16'(i), 16'(i));
        tick();
        tick();
        chk("c2_wrap", txn_count2, 1);
        chk("c16_five", txn_count, 5);

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            in_a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
            in_b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        ovf_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        chk("drain_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cla_io_stage.md
Name: cla_io_stage

Overview:
- Registered handshake wrapper around the combinational gen_cla_decomposed adder.
- Accepts operand pairs over valid/ready and registers them onto the adder inputs.
- Captures the adder sum and derives carry-out and signed overflow from the operand and sum MSBs.
- Presents results downstream over valid/ready, sustaining one add per cycle under intermittent backpressure.

Parameters:
- NBIT, 16, operand/sum width; must match the adder's NBIT.
- CNTW, 16, width of the completed-transaction counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair on in_a/in_b is valid.
- in_ready  output  1  stage can accept an operand pair this cycle.
- in_a  input  NBIT  operand A.
- in_b  input  NBIT  operand B.
- add_a  output  NBIT  registered operand A to the adder's a.
- add_b  output  NBIT  registered operand B to the adder's b.
- add_s  input  NBIT  adder sum (combinational from add_a/add_b).
- out_valid  output  1  result on out_* is valid.
- out_ready  input  1  downstream accepts the result.
- out_s  output  NBIT  registered sum.
- out_cout  output  1  unsigned carry-out of the registered add.
- out_ovf  output  1  two's-complement overflow of the registered add.
- ovf_sticky  output  1  set by any delivered result with out_ovf=1.
- ovf_clr  input  1  synchronous clear of ovf_sticky.
- txn_count  output  CNTW  number of results delivered (out_valid & out_ready).

Behaviour:
- Reset (rst_n low, asynchronous): all of the following go to 0 immediately:
  - v1, v2, add_a, add_b, out_s, out_cout, out_ovf, ovf_sticky, txn_count.
  - out_valid=0, in_ready=1.
  - Any in-flight data is discarded.
- Stage 1, operand register:
  - Holds v1, add_a, add_b.
  - adv2 = v1 & (~v2 | out_ready).
  - in_ready = ~v1 | adv2 (combinational, no bubble).
  - On in_valid & in_ready: add_a<=in_a, add_b<=in_b, v1<=1.
  - Else if adv2: v1<=0.
  - add_a/add_b hold stable while v1=1 and stage 1 is not advancing.
- Stage 2, result register:
  - On adv2: out_s<=add_s, v2<=1.
  - With a=add_a[NBIT-1], b=add_b[NBIT-1], s=add_s[NBIT-1]:
    - out_cout <= (a&b) | ((a^b)&~s).
    - out_ovf <= (a~^b) & (s^a).
  - Else if out_ready: v2<=0.
  - out_valid = v2.
  - out_s, out_cout, out_ovf hold while out_valid & ~out_ready.
- Latency: a pair accepted at edge k appears with out_valid=1 after edge k+1, i.e. 2 cycles in to out.
- Throughput: 1 pair/cycle when out_ready=1 continuously.
- Backpressure:
  - With out_ready=0, the stage absorbs at most two pairs (one per stage), then in_ready=0.
  - When out_ready rises, in_ready rises in the same cycle.
- Simultaneous events:
  - Accept and advance in the same cycle: stage 1 reloads and v1 stays 1.
  - Deliver and refill in the same cycle: v2 stays 1.
- txn_count:
  - Increments by 1 on out_valid & out_ready.
  - Wraps from 2^CNTW-1 to 0 with no flag.
- ovf_sticky:
  - Set on delivery with out_ovf=1.
  - Cleared by ovf_clr; if a set and a clear coincide, set wins.
- Reset mid-operation: both stages empty at once. The first post-reset result corresponds only to the first pair accepted after rst_n deasserts.
- in_a/in_b are sampled only on acceptance. Values while in_valid=0 are ignored.

Test Plan:
- Reset then single adds, NBIT=16, out_ready=1:
  - 2+3 -> out_s=5, cout=0, ovf=0, out_valid exactly 2 cycles after acceptance.
  - 124+15 -> out_s=139.
- Back-to-back stream, in_valid=1 for 4 cycles, out_ready=1:
  - Pairs (0,0), (2,3), (124,3), (54,43) -> outputs 0, 5, 127, 97 on consecutive cycles.
  - txn_count=4 at end.
- Boundaries:
  - 0xFFFF+0x0001 -> out_s=0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 -> out_s=0x8000, cout=0, ovf=1, ovf_sticky=1.
  - 0x8000+0x8000 -> out_s=0, cout=1, ovf=1.
- Backpressure: out_ready=0 while presenting 3 pairs.
  - Only 2 accepted; in_ready=0 from the third.
  - out_s holds the first sum.
  - After out_ready=1, all 3 delivered in order with no loss or duplicates.
- Reset mid-flight: assert rst_n low with both stages full.
  - Outputs go to 0 immediately.
  - After release, no stale result appears.
  - txn_count=0, in_ready=1.
- Sticky and counter:
  - ovf_clr coinciding with an overflowing delivery -> ovf_sticky stays 1.
  - ovf_clr alone -> 0.
  - With CNTW=2, 5 deliveries -> txn_count=1.
